// File: rtl/stopwatch_uart_reporter_if.sv
// UART TX FIFO write port as seen by the stopwatch reporter.
// The reporter drives the write strobe and data; the FIFO returns its full flag.
interface stopwatch_uart_reporter_if;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_full;

    modport master (output wr_uart, output w_data, input tx_full);
    modport slave  (input wr_uart, input w_data, output tx_full);
endinterface

// File: rtl/stopwatch_uart_reporter.sv
// Snapshots the stopwatch digit bus and writes it as ASCII text ("9.59.9\r\n")
// into the UART TX FIFO, on a host request or on a periodic auto-report tick.
//
// state | meaning
// IDLE  | waiting for req, tick or a pending trigger
// DIGIT | emit character of digit idx_q
// DOT   | emit '.' after a digit whose dp bit is set
// CR    | emit carriage return
// LF    | emit line feed, frame done
module stopwatch_uart_reporter #(
    parameter int NUM_DIGITS   = 4,
    parameter int PERIOD_TICKS = 25_000_000,
    parameter int CNT_W        = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] in0_i,
    input  logic [4:0] in1_i,
    input  logic [4:0] in2_i,
    input  logic [4:0] in3_i,
    input  logic [4:0] in4_i,
    input  logic [4:0] in5_i,
    input  logic       req_i,
    input  logic       auto_en_i,
    output logic       busy_o,
    stopwatch_uart_reporter_if.master uart
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] DIGIT = 3'd1;
    localparam logic [2:0] DOT   = 3'd2;
    localparam logic [2:0] CR    = 3'd3;
    localparam logic [2:0] LF    = 3'd4;

    localparam bit             AUTO_OK = (PERIOD_TICKS != 0);
    localparam logic [CNT_W-1:0] LAST  = AUTO_OK ? CNT_W'(PERIOD_TICKS - 1) : '0;
    localparam logic [2:0]     TOP_IDX = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             pend_q, pend_d;
    logic             busy_q, busy_d;
    logic [29:0]      snap_q, snap_d;
    logic [7:0]       last_q, last_d;

    logic       tick, trig, emit, wr;
    logic [4:0] cur;
    logic [7:0] enc, byte_c;

    always_comb begin
        cnt_d = cnt_q;
        if (!AUTO_OK || !auto_en_i || cnt_q == LAST) cnt_d = '0;
        else                                         cnt_d = cnt_q + 1'b1;
    end

    assign tick = AUTO_OK && auto_en_i && (cnt_q == LAST);
    assign trig = req_i | tick;

    always_comb begin
        case (idx_q)
            3'd0:    cur = snap_q[4:0];
            3'd1:    cur = snap_q[9:5];
            3'd2:    cur = snap_q[14:10];
            3'd3:    cur = snap_q[19:15];
            3'd4:    cur = snap_q[24:20];
            3'd5:    cur = snap_q[29:25];
            default: cur = 5'd0;
        endcase
    end

    // Hex-style encoding so out-of-range digit values stay visible to the host.
    assign enc = (cur[3:0] < 4'd10) ? (8'h30 + {4'h0, cur[3:0]})
                                    : (8'h37 + {4'h0, cur[3:0]});

    always_comb begin
        case (state_q)
            DIGIT:   byte_c = enc;
            DOT:     byte_c = 8'h2E;
            CR:      byte_c = 8'h0D;
            LF:      byte_c = 8'h0A;
            default: byte_c = last_q;
        endcase
    end

    assign emit = (state_q != IDLE);
    assign wr   = emit && !uart.tx_full;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        snap_d  = snap_q;
        last_d  = wr ? byte_c : last_q;
        if (state_q != IDLE && trig) pend_d = 1'b1;
        case (state_q)
            IDLE: begin
                if (trig || pend_q) begin
                    state_d = DIGIT;
                    idx_d   = TOP_IDX;
                    pend_d  = 1'b0;
                    busy_d  = 1'b1;
                    snap_d  = {in5_i, in4_i, in3_i, in2_i, in1_i, in0_i};
                end
            end
            DIGIT: begin
                if (wr) begin
                    if (cur[4])              state_d = DOT;
                    else if (idx_q == 3'd0)  state_d = CR;
                    else                     idx_d   = idx_q - 3'd1;
                end
            end
            DOT: begin
                if (wr) begin
                    if (idx_q == 3'd0) state_d = CR;
                    else begin
                        state_d = DIGIT;
                        idx_d   = idx_q - 3'd1;
                    end
                end
            end
            CR: if (wr) state_d = LF;
            LF: begin
                if (wr) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            idx_q   <= 3'd0;
            pend_q  <= 1'b0;
            busy_q  <= 1'b0;
            snap_q  <= '0;
            last_q  <= 8'h00;
        end else begin
            cnt_q   <= cnt_d;
            state_q <= state_d;
            idx_q   <= idx_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            snap_q  <= snap_d;
            last_q  <= last_d;
        end
    end

    // Strobe is combinational on tx_full so a write never lands on a full FIFO.
    assign uart.wr_uart = wr;
    assign uart.w_data  = wr ? byte_c : last_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Directed bench for stopwatch_uart_reporter: table of digit patterns with
// expected ASCII frames, plus sequences for stall, coalescing, auto-report and reset.
module tb_stopwatch_uart_reporter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] in0, in1, in2, in3, in4, in5;
    logic       req = 1'b0;
    logic       auto_en = 1'b0;
    logic       busy;

    stopwatch_uart_reporter_if u ();

    stopwatch_uart_reporter #(
        .NUM_DIGITS  (4),
        .PERIOD_TICKS(100),
        .CNT_W       (7)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in0_i    (in0),
        .in1_i    (in1),
        .in2_i    (in2),
        .in3_i    (in3),
        .in4_i    (in4),
        .in5_i    (in5),
        .req_i    (req),
        .auto_en_i(auto_en),
        .busy_o   (busy),
        .uart     (u.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]      d3, d2, d1, d0;
        logic [0:9][7:0] exp;
        int              len;
    } vec_t;

    vec_t tbl[5];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int viol = 0;
    logic [7:0] bq[$];
    int         cq[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u.wr_uart === 1'b1) begin
            bq.push_back(u.w_data);
            cq.push_back(cyc);
            if (u.tx_full !== 1'b0) viol++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_at(input int i);
        if (i < bq.size()) return bq[i];
        return 8'hxx;
    endfunction

    function automatic int cyc_at(input int i);
        if (i < cq.size()) return cq[i];
        return -1;
    endfunction

    task automatic chk_bytes(input string name, input logic [0:9][7:0] exp, input int len, input int base);
        for (int i = 0; i < len; i++) chk($sformatf("%s byte%0d", name, base + i), {24'h0, byte_at(base + i)}, {24'h0, exp[i]});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_digits(input vec_t v);
        in3 = v.d3; in2 = v.d2; in1 = v.d1; in0 = v.d0;
    endtask

    task automatic pulse_req();
        step();
        req = 1'b1;
        step();
        req = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            step();
            n++;
        end
        if (busy) begin
            errors++;
            checks++;
            $display("FAIL %s timeout: busy still %0b after %0d cycles, required 0", name, busy, bound);
        end
    endtask

    task automatic clear_log();
        bq.delete();
        cq.delete();
        viol = 0;
    endtask

    initial begin
        in0 = 5'd0; in1 = 5'd0; in2 = 5'd0; in3 = 5'd0;
        in4 = {1'b1, 4'd5}; in5 = {1'b1, 4'd6};
        u.tx_full = 1'b0;

        tbl[0] = '{d3: {1'b1,4'd9},  d2: {1'b0,4'd5},  d1: {1'b1,4'd9},  d0: {1'b0,4'd9},
                   exp: {8'h39,8'h2E,8'h35,8'h39,8'h2E,8'h39,8'h0D,8'h0A,8'h00,8'h00}, len: 8};
        tbl[1] = '{d3: {1'b0,4'd0},  d2: {1'b0,4'd0},  d1: {1'b0,4'd0},  d0: {1'b0,4'd0},
                   exp: {8'h30,8'h30,8'h30,8'h30,8'h0D,8'h0A,8'h00,8'h00,8'h00,8'h00}, len: 6};
        tbl[2] = '{d3: {1'b0,4'hA},  d2: {1'b1,4'hB},  d1: {1'b0,4'hF},  d0: {1'b0,4'd1},
                   exp: {8'h41,8'h42,8'h2E,8'h46,8'h31,8'h0D,8'h0A,8'h00,8'h00,8'h00}, len: 7};
        tbl[3] = '{d3: {1'b1,4'd1},  d2: {1'b1,4'd2},  d1: {1'b1,4'd3},  d0: {1'b1,4'd4},
                   exp: {8'h31,8'h2E,8'h32,8'h2E,8'h33,8'h2E,8'h34,8'h2E,8'h0D,8'h0A}, len: 10};
        tbl[4] = '{d3: {1'b0,4'hC},  d2: {1'b0,4'd0},  d1: {1'b0,4'd0},  d0: {1'b1,4'd7},
                   exp: {8'h43,8'h30,8'h30,8'h37,8'h2E,8'h0D,8'h0A,8'h00,8'h00,8'h00}, len: 7};

        // reset state
        #12;
        chk("rst wr_uart", {31'h0, u.wr_uart}, 32'h0);
        chk("rst w_data", {24'h0, u.w_data}, 32'h0);
        chk("rst busy", {31'h0, busy}, 32'h0);
        rst_n = 1'b1;
        repeat (2) step();

        // table vectors
        for (int k = 0; k < 5; k++) begin
            set_digits(tbl[k]);
            clear_log();
            pulse_req();
            wait_idle($sformatf("vec%0d", k), 40);
            chk($sformatf("vec%0d count", k), bq.size(), tbl[k].len);
            chk_bytes($sformatf("vec%0d", k), tbl[k].exp, tbl[k].len, 0);
            chk($sformatf("vec%0d span", k), cyc_at(tbl[k].len - 1) - cyc_at(0), tbl[k].len - 1);
            step();
            chk($sformatf("vec%0d hold", k), {24'h0, u.w_data}, 32'h0A);
        end

        // tx_full high for 5 cycles during the 3rd byte
        set_digits(tbl[0]);
        clear_log();
        pulse_req();
        begin
            int n = 0;
            while (bq.size() < 2 && n < 20) begin step(); n++; end
        end
        u.tx_full = 1'b1;
        repeat (5) step();
        u.tx_full = 1'b0;
        wait_idle("stall", 40);
        chk("stall count", bq.size(), 8);
        chk_bytes("stall", tbl[0].exp, 8, 0);
        chk("stall span", cyc_at(7) - cyc_at(0), 12);
        chk("stall no write while full", viol, 0);

        // extra requests during a frame coalesce into one more frame
        clear_log();
        pulse_req();
        repeat (3) begin
            step();
            req = 1'b1;
            step();
            req = 1'b0;
        end
        wait_idle("coalesce f1", 40);
        repeat (2) step();
        wait_idle("coalesce f2", 40);
        repeat (20) step();
        chk("coalesce count", bq.size(), 16);
        chk_bytes("coalesce f1", tbl[0].exp, 8, 0);
        chk_bytes("coalesce f2", tbl[0].exp, 8, 8);

        // digit change after acceptance does not tear the frame
        clear_log();
        pulse_req();
        in0 = {1'b0, 4'd3};
        wait_idle("snapshot", 40);
        chk("snapshot count", bq.size(), 8);
        chk("snapshot last digit", {24'h0, byte_at(5)}, 32'h39);
        in0 = {1'b0, 4'd9};
        repeat (2) step();

        // periodic auto-report
        clear_log();
        begin
            int x;
            step();
            auto_en = 1'b1;
            x = cyc;
            repeat (350) step();
            chk("auto count", bq.size(), 24);
            chk("auto first start", cyc_at(0) - x, 100);
            chk("auto period 1", cyc_at(8) - cyc_at(0), 100);
            chk("auto period 2", cyc_at(16) - cyc_at(8), 100);
            chk_bytes("auto f3", tbl[0].exp, 8, 16);
        end
        auto_en = 1'b0;
        step();
        chk("auto off counter", {25'h0, dut.cnt_q}, 32'h0);
        repeat (250) step();
        chk("auto off no frames", bq.size(), 24);
        chk("auto off counter held", {25'h0, dut.cnt_q}, 32'h0);

        // reset mid-frame aborts and clears pending
        clear_log();
        pulse_req();
        req = 1'b1;
        step();
        req = 1'b0;
        begin
            int n = 0;
            while (bq.size() < 3 && n < 20) begin step(); n++; end
        end
        rst_n = 1'b0;
        #1;
        chk("abort busy", {31'h0, busy}, 32'h0);
        chk("abort wr_uart", {31'h0, u.wr_uart}, 32'h0);
        chk("abort w_data", {24'h0, u.w_data}, 32'h0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("abort truncated", bq.size(), 3);
        chk("abort stays idle", {31'h0, busy}, 32'h0);

        set_digits(tbl[4]);
        clear_log();
        pulse_req();
        wait_idle("after reset", 40);
        chk("after reset count", bq.size(), 7);
        chk_bytes("after reset", tbl[4].exp, 7, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global timeout: simulation time exceeded, required completion");
        $fatal(1, "timeout");
    end

endmodule
